camera_color_tracker: RTL and testbench
=======================================

# camera_color_tracker

Parametrised YCbCr 4:2:2 camera capture stage with per-pixel chroma keying, run-length filtering and per-frame bounding-box extraction. It sits between the camera byte bus and the frame-buffer write port. It emits one 8-bit pixel plus a linear address per write. At each frame boundary it publishes the bounding box and match count of the detected colour.

## Interface
- H_RES, 640: active pixels per line
- V_RES, 480: active lines per frame
- RUN_MIN, 5: consecutive matches in a line required before a pixel qualifies (1..255)
- MARK_VAL, 255: pixel value for matched pixels in overlay modes
- BOX_VAL, 254: pixel value for bounding-box outline in mode 3
- pclk  in  1  pixel-byte clock; the only clock
- reset  in  1  synchronous, active-high
- href  in  1  line-valid from camera
- vsync  in  1  frame sync from camera; rising edge ends a frame
- byte_camera  in  8  camera data, order Cb,Y0,Cr,Y1
- mode  in  2  0=luma, 1=binary mask, 2=overlay, 3=overlay+previous-frame box
- cb_min, cb_max, cr_min, cr_max, y_min  in  8 each  match thresholds, inclusive
- enable_write_memory  out  1  write strobe
- pos_pxl  out  clog2(H_RES*V_RES)  write address
- pixel_out  out  8  pixel to write
- box_x_min, box_x_max  out  clog2(H_RES)  published box columns
- box_y_min, box_y_max  out  clog2(V_RES)  published box rows
- match_count  out  clog2(H_RES*V_RES)+1  qualified pixels in last frame
- found  out  1  match_count of last frame nonzero
- box_valid  out  1  one-cycle pulse when box outputs update

## Operation
- Byte phase counter 0..3 advances on each pclk with href high and forces to 0 on any cycle with href low.
  - Phase 0 latches Cb, phase 1 Y0, phase 2 Cr, phase 3 Y1.
  - A partial group at href fall is discarded.
- Match for pixel k (k=0,1): cb_min<=Cb<=cb_max, cr_min<=Cr<=cr_max, Yk>=y_min. Cb/Cr are shared by both pixels.
- Thresholds and mode are registered on the vsync rising edge and on reset. Mid-frame changes take effect next frame.
- Run filter: run_cnt (8 bit, saturating) increments on match and clears on non-match and at line start. A pixel qualifies when the incremented run_cnt>=RUN_MIN.
- Pixel value by mode:
  - 0: Y.
  - 1: 255 if match, else 0.
  - 2: MARK_VAL if qualified, else Y>>1.
  - 3: as mode 2, except BOX_VAL on the published box outline, which requires found=1. Outline means (col in {x_min,x_max} and row in [y_min,y_max]) or (row in {y_min,y_max} and col in [x_min,x_max]). Box takes priority.
- col increments per emitted pixel. At the href falling edge, row increments (if col>0) and col clears. col, row, run_cnt and pos_pxl clear while vsync is high.
- pos_pxl = running count of writes in the frame; it advances only on a write.
- Pixels with col>=H_RES or row>=V_RES are not written: strobe low, no address advance, no box update.
- Accumulators per frame:
  - x_min, y_min init to all-ones; x_max, y_max init to 0; count init to 0.
  - Each qualified, in-range pixel updates min/max and increments count.
- vsync rising edge: copy accumulators to outputs (box outputs forced to 0 if count=0), set found=(count!=0), pulse box_valid, then re-init the accumulators.

## Timing
- Reset values:
  - All outputs 0.
  - Phase, col, row and run_cnt 0.
  - Accumulators at their init values.
  - Registered thresholds from the ports; registered mode 0.
- Pixel 0 of a group: enable_write_memory=1 with pixel_out/pos_pxl valid in the cycle after the Y1 byte is sampled.
- Pixel 1 of a group: the following cycle, regardless of href.
- Two consecutive strobes every 4 cycles; strobe low otherwise.
- box_valid asserts the cycle after the vsync 0->1 sample. Box outputs change in that same cycle.
- A pixel emitted in the same cycle the vsync rise is detected belongs to the ending frame.
- reset asserted mid-line: outputs 0 next cycle, and any partial group or pending pixel 1 is dropped.
- pos_pxl never exceeds H_RES*V_RES-1 (guaranteed by the range gate).

## Test plan
- Gray line, mode 0: 4 groups Cb=128,Y0=40,Cr=128,Y1=80, 16 bytes -> 8 writes at pos_pxl 0..7, pixel_out alternating 40/80, 1-cycle latency after each Y1.
- Mask, mode 1, thresholds cb 150..255, cr 140..255, y_min 0: group Cb=160,Cr=150 -> two pixels =255; Cb=149 -> 0.
- Run filter, mode 2, RUN_MIN=5: 8 matching pixels then 2 non-matching -> pixels 0-3 = Y>>1, pixels 4-7 = 255, then Y>>1. After the vsync rise, box_x_min=4, box_x_max=7, match_count=4, found=1, and box_valid is one cycle high.
- Two-line box with small H_RES=8/V_RES=4: qualified pixels at (5,1) and (7,2) -> box (5..7, 1..2), count 2. The next frame in mode 3 shows 254 on the outline.
- Empty frame: no matches -> found=0, box outputs 0, match_count=0, box_valid pulses.
- Overrun/reset: 10 pixels on a line with H_RES=8 -> only 8 writes. reset mid-group -> strobe low next cycle, and the next line starts at pos_pxl 0 with phase 0.

Source files
------------

// File: rtl/camera_color_tracker.sv
// camera_color_tracker: YCbCr 4:2:2 capture stage with chroma keying,
// run-length filtering and per-frame bounding-box extraction.
// Ports:
//   pclk, reset                      - clock, synchronous active-high reset
//   href, vsync, byte_camera         - camera byte bus (Cb,Y0,Cr,Y1 order)
//   mode, cb_*/cr_*/y_min            - output mode and match thresholds
//   enable_write_memory, pos_pxl,
//   pixel_out                        - frame-buffer write port
//   box_*, match_count, found,
//   box_valid                        - per-frame detection results
module camera_color_tracker #(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned RUN_MIN  = 5,
  parameter int unsigned MARK_VAL = 255,
  parameter int unsigned BOX_VAL  = 254,
  localparam int unsigned AW = $clog2(H_RES * V_RES),
  localparam int unsigned XW = $clog2(H_RES),
  localparam int unsigned YW = $clog2(V_RES),
  localparam int unsigned CW = AW + 1
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          href,
  input  logic          vsync,
  input  logic [7:0]    byte_camera,
  input  logic [1:0]    mode,
  input  logic [7:0]    cb_min,
  input  logic [7:0]    cb_max,
  input  logic [7:0]    cr_min,
  input  logic [7:0]    cr_max,
  input  logic [7:0]    y_min,
  output logic          enable_write_memory,
  output logic [AW-1:0] pos_pxl,
  output logic [7:0]    pixel_out,
  output logic [XW-1:0] box_x_min,
  output logic [XW-1:0] box_x_max,
  output logic [YW-1:0] box_y_min,
  output logic [YW-1:0] box_y_max,
  output logic [CW-1:0] match_count,
  output logic          found,
  output logic          box_valid
);

  // col/row are wider than the frame so overrun pixels can be detected
  localparam int unsigned LW = 16;

  logic [1:0]    phase_q, phase_d;
  logic          href_q, href_d, vsync_q, vsync_d;
  logic [7:0]    cb_q, cb_d, y0_q, y0_d, cr_q, cr_d;
  logic          pend_q, pend_d, pend_m_q, pend_m_d;
  logic [7:0]    pend_y_q, pend_y_d;
  logic [7:0]    run_q, run_d;
  logic [LW-1:0] col_q, col_d, row_q, row_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [7:0]    cbmin_q, cbmin_d, cbmax_q, cbmax_d, crmin_q, crmin_d;
  logic [7:0]    crmax_q, crmax_d, ymin_th_q, ymin_th_d;
  logic [1:0]    mode_q, mode_d;
  logic          we_q, we_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [7:0]    pix_q, pix_d;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, bxmin_q, bxmin_d, bxmax_q, bxmax_d;
  logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d, bymin_q, bymin_d, bymax_q, bymax_d;
  logic [CW-1:0] cnt_q, cnt_d, mcnt_q, mcnt_d;
  logic          found_q, found_d, bvalid_q, bvalid_d;

  logic          grp_c, chroma_ok_c, emit_c, emit_m_c, qual_c, in_range_c, on_box_c;
  logic [7:0]    emit_y_c, run_inc_c, pix_val_c;

  // Per-pixel datapath: pixel 0 is formed on the Y1 byte, pixel 1 one cycle later
  always_comb begin
    grp_c       = href && (phase_q == 2'd3);
    chroma_ok_c = (cb_q >= cbmin_q) && (cb_q <= cbmax_q) &&
                  (cr_q >= crmin_q) && (cr_q <= crmax_q);
    emit_c      = grp_c || pend_q;
    emit_y_c    = grp_c ? y0_q : pend_y_q;
    emit_m_c    = grp_c ? (chroma_ok_c && (y0_q >= ymin_th_q)) : pend_m_q;
    run_inc_c   = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
    qual_c      = emit_m_c && (32'(run_inc_c) >= RUN_MIN);
    in_range_c  = (col_q < LW'(H_RES)) && (row_q < LW'(V_RES));
    on_box_c    = found_q &&
                  (((col_q == LW'(bxmin_q)) || (col_q == LW'(bxmax_q))) &&
                    (row_q >= LW'(bymin_q)) && (row_q <= LW'(bymax_q)) ||
                   ((row_q == LW'(bymin_q)) || (row_q == LW'(bymax_q))) &&
                    (col_q >= LW'(bxmin_q)) && (col_q <= LW'(bxmax_q)));
    case (mode_q)
      2'd0:    pix_val_c = emit_y_c;
      2'd1:    pix_val_c = emit_m_c ? 8'hFF : 8'h00;
      2'd2:    pix_val_c = qual_c ? 8'(MARK_VAL) : {1'b0, emit_y_c[7:1]};
      default: pix_val_c = on_box_c ? 8'(BOX_VAL) :
                           (qual_c ? 8'(MARK_VAL) : {1'b0, emit_y_c[7:1]});
    endcase
  end

  // Next-state logic
  always_comb begin
    phase_d = href ? phase_q + 2'd1 : 2'd0;
    href_d  = href;
    vsync_d = vsync;
    cb_d = cb_q; y0_d = y0_q; cr_d = cr_q;
    pend_d = 1'b0; pend_y_d = pend_y_q; pend_m_d = pend_m_q;
    run_d = run_q; col_d = col_q; row_d = row_q; wcnt_d = wcnt_q;
    cbmin_d = cbmin_q; cbmax_d = cbmax_q; crmin_d = crmin_q;
    crmax_d = crmax_q; ymin_th_d = ymin_th_q; mode_d = mode_q;
    we_d = 1'b0; pos_d = pos_q; pix_d = pix_q;
    xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q; cnt_d = cnt_q;
    bxmin_d = bxmin_q; bxmax_d = bxmax_q; bymin_d = bymin_q; bymax_d = bymax_q;
    mcnt_d = mcnt_q; found_d = found_q; bvalid_d = 1'b0;

    if (href) begin
      case (phase_q)
        2'd0:    cb_d = byte_camera;
        2'd1:    y0_d = byte_camera;
        2'd2:    cr_d = byte_camera;
        default: begin
          pend_d   = 1'b1;
          pend_y_d = byte_camera;
          pend_m_d = chroma_ok_c && (byte_camera >= ymin_th_q);
        end
      endcase
    end

    if (emit_c) begin
      run_d = emit_m_c ? run_inc_c : 8'd0;
      col_d = (col_q == '1) ? col_q : col_q + LW'(1);
      if (in_range_c) begin
        we_d   = 1'b1;
        pos_d  = wcnt_q;
        pix_d  = pix_val_c;
        wcnt_d = wcnt_q + AW'(1);
        if (qual_c) begin
          if (XW'(col_q) < xmin_q) xmin_d = XW'(col_q);
          if (XW'(col_q) > xmax_q) xmax_d = XW'(col_q);
          if (YW'(row_q) < ymin_q) ymin_d = YW'(row_q);
          if (YW'(row_q) > ymax_q) ymax_d = YW'(row_q);
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Line end: a pixel emitted in this cycle still counts toward the row
    if (href_q && !href) begin
      col_d = '0;
      run_d = 8'd0;
      if ((col_q != '0) || emit_c) row_d = (row_q == '1) ? row_q : row_q + LW'(1);
    end

    // Frame end: publish including any pixel emitted this cycle, then re-arm
    if (vsync && !vsync_q) begin
      found_d   = (cnt_d != '0);
      mcnt_d    = cnt_d;
      bxmin_d   = found_d ? xmin_d : '0;
      bxmax_d   = found_d ? xmax_d : '0;
      bymin_d   = found_d ? ymin_d : '0;
      bymax_d   = found_d ? ymax_d : '0;
      bvalid_d  = 1'b1;
      xmin_d = '1; xmax_d = '0; ymin_d = '1; ymax_d = '0; cnt_d = '0;
      cbmin_d = cb_min; cbmax_d = cb_max; crmin_d = cr_min;
      crmax_d = cr_max; ymin_th_d = y_min; mode_d = mode;
    end

    if (vsync) begin
      col_d = '0; row_d = '0; run_d = 8'd0; wcnt_d = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      phase_q <= 2'd0; href_q <= 1'b0; vsync_q <= 1'b0;
      cb_q <= 8'd0; y0_q <= 8'd0; cr_q <= 8'd0;
      pend_q <= 1'b0; pend_y_q <= 8'd0; pend_m_q <= 1'b0;
      run_q <= 8'd0; col_q <= '0; row_q <= '0; wcnt_q <= '0;
      cbmin_q <= cb_min; cbmax_q <= cb_max; crmin_q <= cr_min;
      crmax_q <= cr_max; ymin_th_q <= y_min; mode_q <= 2'd0;
      we_q <= 1'b0; pos_q <= '0; pix_q <= 8'd0;
      xmin_q <= '1; xmax_q <= '0; ymin_q <= '1; ymax_q <= '0; cnt_q <= '0;
      bxmin_q <= '0; bxmax_q <= '0; bymin_q <= '0; bymax_q <= '0;
      mcnt_q <= '0; found_q <= 1'b0; bvalid_q <= 1'b0;
    end else begin
      phase_q <= phase_d; href_q <= href_d; vsync_q <= vsync_d;
      cb_q <= cb_d; y0_q <= y0_d; cr_q <= cr_d;
      pend_q <= pend_d; pend_y_q <= pend_y_d; pend_m_q <= pend_m_d;
      run_q <= run_d; col_q <= col_d; row_q <= row_d; wcnt_q <= wcnt_d;
      cbmin_q <= cbmin_d; cbmax_q <= cbmax_d; crmin_q <= crmin_d;
      crmax_q <= crmax_d; ymin_th_q <= ymin_th_d; mode_q <= mode_d;
      we_q <= we_d; pos_q <= pos_d; pix_q <= pix_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d; cnt_q <= cnt_d;
      bxmin_q <= bxmin_d; bxmax_q <= bxmax_d; bymin_q <= bymin_d; bymax_q <= bymax_d;
      mcnt_q <= mcnt_d; found_q <= found_d; bvalid_q <= bvalid_d;
    end
  end

  assign enable_write_memory = we_q;
  assign pos_pxl             = pos_q;
  assign pixel_out           = pix_q;
  assign box_x_min           = bxmin_q;
  assign box_x_max           = bxmax_q;
  assign box_y_min           = bymin_q;
  assign box_y_max           = bymax_q;
  assign match_count         = mcnt_q;
  assign found               = found_q;
  assign box_valid           = bvalid_q;

endmodule

// File: tb/tb_camera_color_tracker.sv
// Testbench for camera_color_tracker: a 640x480 instance and an 8x4
// instance share one stimulus bus; writes of each are logged and compared
// against expected {address, pixel, cycle} lists built by the bench.
module tb_camera_color_tracker;

  logic       pclk = 1'b0;
  logic       reset, href, vsync;
  logic [7:0] byte_camera;
  logic [1:0] mode;
  logic [7:0] cb_min, cb_max, cr_min, cr_max, y_min;

  logic        b_we, b_found, b_bv;
  logic [18:0] b_pos;
  logic [7:0]  b_pix;
  logic [9:0]  b_xmin, b_xmax;
  logic [8:0]  b_ymin, b_ymax;
  logic [19:0] b_cnt;

  logic       s_we, s_found, s_bv;
  logic [4:0] s_pos;
  logic [7:0] s_pix;
  logic [2:0] s_xmin, s_xmax;
  logic [1:0] s_ymin, s_ymax;
  logic [5:0] s_cnt;

  camera_color_tracker #(.H_RES(640), .V_RES(480), .RUN_MIN(5)) u_big (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .byte_camera(byte_camera),
    .mode(mode), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .y_min(y_min), .enable_write_memory(b_we), .pos_pxl(b_pos), .pixel_out(b_pix),
    .box_x_min(b_xmin), .box_x_max(b_xmax), .box_y_min(b_ymin), .box_y_max(b_ymax),
    .match_count(b_cnt), .found(b_found), .box_valid(b_bv));

  camera_color_tracker #(.H_RES(8), .V_RES(4), .RUN_MIN(1)) u_small (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .byte_camera(byte_camera),
    .mode(mode), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .y_min(y_min), .enable_write_memory(s_we), .pos_pxl(s_pos), .pixel_out(s_pix),
    .box_x_min(s_xmin), .box_x_max(s_xmax), .box_y_min(s_ymin), .box_y_max(s_ymax),
    .match_count(s_cnt), .found(s_found), .box_valid(s_bv));

  always #5 pclk = ~pclk;

  typedef struct { int addr; int pix; int cyc; } wr_t;
  typedef struct { int m; int cb; int y0; int cr; int y1; int e0; int e1; } vec_t;

  wr_t big_q[$], small_q[$], exp_q[$];
  int  cyc = 0;
  int  total = 0, bad = 0;
  int  bv_b0, bv_b1, bv_s0, bv_s1;

  always @(posedge pclk) cyc <= cyc + 1;

  // Write loggers, sampled mid-cycle
  always @(negedge pclk) begin
    if (b_we === 1'b1) big_q.push_back('{int'(b_pos), int'(b_pix), cyc});
    if (s_we === 1'b1) small_q.push_back('{int'(s_pos), int'(s_pix), cyc});
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_byte(input int b);
    href = 1'b1;
    byte_camera = 8'(b);
    @(posedge pclk); #1;
  endtask

  // Returns the cycle stamp at which pixel 0 of this group is visible
  task automatic send_group(input int cb, input int y0, input int cr, input int y1,
                            output int ycyc);
    send_byte(cb); send_byte(y0); send_byte(cr); send_byte(y1);
    ycyc = cyc;
  endtask

  task automatic idle(input int n);
    href = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic vsync_pulse(input int m);
    mode = 2'(m);
    href = 1'b0;
    vsync = 1'b1;
    @(posedge pclk); #1;
    bv_b0 = int'(b_bv); bv_s0 = int'(s_bv);
    @(posedge pclk); #1;
    bv_b1 = int'(b_bv); bv_s1 = int'(s_bv);
    vsync = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic clear_logs();
    big_q.delete(); small_q.delete(); exp_q.delete();
  endtask

  task automatic cmp_q(input bit sm, input string nm);
    int  n;
    wr_t w;
    n = sm ? small_q.size() : big_q.size();
    check({nm, "_nwr"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      if (sm) w = small_q[i]; else w = big_q[i];
      check($sformatf("%s_addr%0d", nm, i), w.addr, exp_q[i].addr);
      check($sformatf("%s_pix%0d", nm, i), w.pix, exp_q[i].pix);
      if (exp_q[i].cyc >= 0) check($sformatf("%s_cyc%0d", nm, i), w.cyc, exp_q[i].cyc);
    end
  endtask

  // Expected box outline for the 8x4 frame with box cols 5..7, rows 1..2
  function automatic int outline_pix(input int r, input int c);
    if (((c == 5 || c == 7) && r >= 1 && r <= 2) || ((r == 1 || r == 2) && c >= 5 && c <= 7))
      return 254;
    return 50;
  endfunction

  vec_t tbl[11];
  int   yc, addr, cur_mode;

  initial begin
    tbl[0]  = '{0, 128, 40, 128, 80, 40, 80};
    tbl[1]  = '{0, 128, 40, 128, 80, 40, 80};
    tbl[2]  = '{0, 128, 40, 128, 80, 40, 80};
    tbl[3]  = '{0, 128, 40, 128, 80, 40, 80};
    tbl[4]  = '{1, 160, 10, 150, 20, 255, 255};
    tbl[5]  = '{1, 149, 10, 150, 20, 0, 0};
    tbl[6]  = '{1, 160, 10, 139, 20, 0, 0};
    tbl[7]  = '{1, 255, 10, 255, 20, 255, 255};
    tbl[8]  = '{1, 150, 10, 140, 11, 255, 255};
    tbl[9]  = '{1, 160, 9, 150, 10, 0, 255};
    tbl[10] = '{1, 100, 60, 150, 60, 0, 0};

    reset = 1'b1; href = 1'b0; vsync = 1'b0; byte_camera = 8'd0; mode = 2'd0;
    cb_min = 8'd150; cb_max = 8'd255; cr_min = 8'd140; cr_max = 8'd255; y_min = 8'd10;
    repeat (3) begin @(posedge pclk); #1; end

    check("rst_we", int'(b_we), 0);
    check("rst_pos", int'(b_pos), 0);
    check("rst_pix", int'(b_pix), 0);
    check("rst_cnt", int'(b_cnt), 0);
    check("rst_found", int'(b_found), 0);
    check("rst_bv", int'(b_bv), 0);
    check("rst_xmax", int'(b_xmax), 0);
    check("rst_s_we", int'(s_we), 0);
    reset = 1'b0;

    // Gray line (mode 0) then mask vectors (mode 1)
    clear_logs();
    addr = 0; cur_mode = 0;
    foreach (tbl[i]) begin
      if (tbl[i].m != cur_mode) begin
        idle(2);
        vsync_pulse(tbl[i].m);
        cur_mode = tbl[i].m;
        addr = 0;
      end
      send_group(tbl[i].cb, tbl[i].y0, tbl[i].cr, tbl[i].y1, yc);
      exp_q.push_back('{addr, tbl[i].e0, yc});
      exp_q.push_back('{addr + 1, tbl[i].e1, yc + 1});
      addr += 2;
    end
    idle(3);
    cmp_q(1'b0, "table");

    // Run filter in mode 2
    vsync_pulse(2);
    clear_logs();
    for (int g = 0; g < 5; g++) begin
      if (g < 4) send_group(160, 100, 150, 100, yc);
      else       send_group(100, 60, 150, 60, yc);
      exp_q.push_back('{2*g,     (g == 4) ? 30 : (g >= 2 ? 255 : 50), yc});
      exp_q.push_back('{2*g + 1, (g == 4) ? 30 : (g >= 2 ? 255 : 50), yc + 1});
    end
    idle(2);
    cmp_q(1'b0, "run");
    vsync_pulse(2);
    check("run_bv0", bv_b0, 1);
    check("run_bv1", bv_b1, 0);
    check("run_xmin", int'(b_xmin), 4);
    check("run_xmax", int'(b_xmax), 7);
    check("run_ymin", int'(b_ymin), 0);
    check("run_ymax", int'(b_ymax), 0);
    check("run_cnt", int'(b_cnt), 4);
    check("run_found", int'(b_found), 1);

    // Empty frame
    send_group(100, 100, 100, 100, yc);
    send_group(100, 100, 100, 100, yc);
    idle(2);
    vsync_pulse(2);
    check("empty_bv0", bv_b0, 1);
    check("empty_bv1", bv_b1, 0);
    check("empty_found", int'(b_found), 0);
    check("empty_cnt", int'(b_cnt), 0);
    check("empty_xmin", int'(b_xmin), 0);
    check("empty_xmax", int'(b_xmax), 0);
    check("empty_ymin", int'(b_ymin), 0);

    // Two-line box on the 8x4 instance
    reset = 1'b1; idle(2); reset = 1'b0;
    vsync_pulse(2);
    for (int l = 0; l < 3; l++) begin
      for (int g = 0; g < 4; g++) begin
        if ((l == 1 && g == 2) || (l == 2 && g == 3)) send_group(160, 0, 150, 100, yc);
        else                                          send_group(100, 100, 100, 100, yc);
      end
      idle(2);
    end
    vsync_pulse(3);
    check("box_bv0", bv_s0, 1);
    check("box_bv1", bv_s1, 0);
    check("box_xmin", int'(s_xmin), 5);
    check("box_xmax", int'(s_xmax), 7);
    check("box_ymin", int'(s_ymin), 1);
    check("box_ymax", int'(s_ymax), 2);
    check("box_cnt", int'(s_cnt), 2);
    check("box_found", int'(s_found), 1);

    // Mode 3 outline in the following frame
    clear_logs();
    for (int l = 0; l < 3; l++) begin
      for (int g = 0; g < 4; g++) begin
        send_group(100, 100, 100, 100, yc);
        exp_q.push_back('{l*8 + 2*g,     outline_pix(l, 2*g),     yc});
        exp_q.push_back('{l*8 + 2*g + 1, outline_pix(l, 2*g + 1), yc + 1});
      end
      idle(2);
    end
    cmp_q(1'b1, "outline");

    // Overrun: 10 pixels on an 8-wide line
    vsync_pulse(0);
    clear_logs();
    for (int g = 0; g < 5; g++) begin
      send_group(128, 10 + 2*g, 128, 11 + 2*g, yc);
      if (g < 4) begin
        exp_q.push_back('{2*g,     10 + 2*g, yc});
        exp_q.push_back('{2*g + 1, 11 + 2*g, yc + 1});
      end
    end
    idle(2);
    cmp_q(1'b1, "overrun");

    // Reset while pixel 1 is pending, then a fresh line
    clear_logs();
    send_group(128, 60, 128, 61, yc);
    exp_q.push_back('{8, 60, yc});
    reset = 1'b1;
    send_byte(128);
    check("rst_mid_we", int'(s_we), 0);
    check("rst_mid_pix", int'(s_pix), 0);
    check("rst_mid_pos", int'(s_pos), 0);
    send_byte(77);
    reset = 1'b0;
    send_group(128, 70, 128, 71, yc);
    exp_q.push_back('{0, 70, yc});
    exp_q.push_back('{1, 71, yc + 1});
    idle(3);
    cmp_q(1'b1, "rst_line");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
